// File: rtl/ase_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters; optional ASE_ARB_STATS_EN adds stall_cnt.
// Latency: 1 cycle from req_valid&req_ready to the registered fifo_wr_en/fifo_din; 1 word/cycle.
// Backpressure: no grant unless fifo_count plus the in-flight write leaves room in the FIFO.
module ase_fifo_wr_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NUM_REQ     = 4,
    parameter int DEPTH_BASE2 = 4,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]   fifo_din,
    input  logic [DEPTH_BASE2:0]             fifo_count,
    input  logic                             fifo_overflow,
    output logic                             err_overflow
`ifdef ASE_ARB_STATS_EN
    ,
    output logic [31:0]                      stall_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_BASE2;
    localparam int PW    = ID_WIDTH + 1;

    logic                           fifo_wr_en_q, fifo_wr_en_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic [ID_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
    logic                           err_overflow_q, err_overflow_d;

    logic [DEPTH_BASE2+1:0]         occupancy;
    logic                           space;
    logic                           gnt_any;
    logic [ID_WIDTH-1:0]            gnt_idx;
    logic [NUM_REQ-1:0]             gnt;
    logic [PW-1:0]                  cand;
    logic [PW-1:0]                  nxt_ptr;
    logic [DATA_WIDTH-1:0]          sel_data;

    // The word registered last cycle is not yet in fifo_count, so count it as occupied.
    assign occupancy = {1'b0, fifo_count} + {{(DEPTH_BASE2+1){1'b0}}, fifo_wr_en_q};
    assign space     = occupancy < (DEPTH_BASE2+2)'(DEPTH);

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + PW'(k);
            if (cand >= PW'(NUM_REQ)) begin
                cand = cand - PW'(NUM_REQ);
            end
            if (!gnt_any && space && req_valid[cand[ID_WIDTH-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = rst_n ? gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_WIDTH'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        fifo_wr_en_d   = 1'b0;
        fifo_din_d     = fifo_din_q;
        rr_ptr_d       = rr_ptr_q;
        err_overflow_d = err_overflow_q | fifo_overflow;
        nxt_ptr        = {1'b0, gnt_idx} + PW'(1);
        if (nxt_ptr >= PW'(NUM_REQ)) begin
            nxt_ptr = '0;
        end
        if (gnt_any) begin
            fifo_wr_en_d = 1'b1;
            fifo_din_d   = {gnt_idx, sel_data};
            rr_ptr_d     = nxt_ptr[ID_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en_q   <= 1'b0;
            fifo_din_q     <= '0;
            rr_ptr_q       <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_din_q     <= fifo_din_d;
            rr_ptr_q       <= rr_ptr_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_din     = fifo_din_q;
    assign err_overflow = err_overflow_q;

`ifdef ASE_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where someone wants to write but the FIFO has no room; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req_valid) && !space && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
